rnn_result_tx: RTL and testbench

- Transmit-side counterpart of the feature receive path feeding the RNN core.
- Captures one RNN inference result (vad word plus NB_BANDS gain words, IEEE-754 float32) and serializes it as a framed byte stream.
- The stream goes to the byte-wide UART transmitter over a valid/ready handshake.
- Sits between the dense2/gains outputs of the RNN top and the UART TX.

---
 rtl/rnn_result_tx_pkg.sv | 30 +++
 rtl/rnn_result_tx.sv | 96 +++++++++
 tb/tb_rnn_result_tx.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/rnn_result_tx_pkg.sv
// Shared constants, FSM state encoding and byte-select helper for the RNN
// result framing path (transmit serializer and receive-side deframer).
package rnn_result_tx_pkg;

  localparam int unsigned NB_BANDS            = 22;
  localparam int unsigned FLOAT_W             = 32;
  localparam logic [7:0]  RNN_HDR             = 8'hA5;
  localparam int unsigned FRAME_WORDS         = NB_BANDS + 1;
  localparam int unsigned FRAME_PAYLOAD_BYTES = 4 * FRAME_WORDS;
  localparam int unsigned FRAME_BITS          = FLOAT_W * FRAME_WORDS;
  localparam int unsigned WORD_IDX_W          = $clog2(FRAME_WORDS);
  localparam int unsigned CNT_W               = $clog2(FRAME_PAYLOAD_BYTES);

  typedef enum logic [1:0] {
    RNN_IDLE    = 2'd0,
    RNN_HEADER  = 2'd1,
    RNN_PAYLOAD = 2'd2,
    RNN_CHECK   = 2'd3
  } rnn_state_e;

  // Word 0 sits in the low FLOAT_W bits; byte 3 is the MSB of a word.
  function automatic logic [7:0] rnn_byte_sel(
    input logic [FRAME_BITS-1:0] words,
    input logic [WORD_IDX_W-1:0] word_idx,
    input logic [1:0]            byte_idx
  );
    return words[int'(word_idx) * FLOAT_W + int'(byte_idx) * 8 +: 8];
  endfunction

endpackage

// File: rtl/rnn_result_tx.sv
// Serializes one RNN result (vad + NB_BANDS gains, float32) into a framed
// byte stream: HDR, payload bytes MSB-first per word, XOR checksum.
module rnn_result_tx
  import rnn_result_tx_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        res_valid,
  output logic                        res_ready,
  input  logic [FLOAT_W-1:0]          vad,
  input  logic [NB_BANDS*FLOAT_W-1:0] gains,
  output logic [7:0]                  tx_data,
  output logic                        tx_valid,
  input  logic                        tx_ready,
  output logic [15:0]                 frames_sent
);

  localparam logic [1:0] IDLE    = RNN_IDLE;
  localparam logic [1:0] HEADER  = RNN_HEADER;
  localparam logic [1:0] PAYLOAD = RNN_PAYLOAD;
  localparam logic [1:0] CHECK   = RNN_CHECK;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_PAYLOAD_BYTES - 1);

  logic [1:0]            state;
  logic [CNT_W-1:0]      cnt;
  logic [7:0]            csum;
  logic [FRAME_BITS-1:0] shadow;
  logic [CNT_W-1:0]      cnt_nxt;

  assign cnt_nxt = cnt + 1'b1;

  // Shadow buffer: freeze the result on capture so the frame in flight is immune to input changes.
  always_ff @(posedge clk) begin
    if (state == IDLE && res_valid)
      shadow <= {gains, vad};
  end

  // Framing FSM; outputs are loaded one byte ahead so tx_data/tx_valid stay registered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      tx_valid    <= 1'b0;
      tx_data     <= 8'h00;
      res_ready   <= 1'b1;
      frames_sent <= 16'h0000;
      cnt         <= '0;
      csum        <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (res_valid) begin
            state     <= HEADER;
            tx_valid  <= 1'b1;
            tx_data   <= RNN_HDR;
            res_ready <= 1'b0;
            cnt       <= '0;
            csum      <= 8'h00;
          end
        end
        HEADER: begin
          if (tx_ready) begin
            state   <= PAYLOAD;
            tx_data <= rnn_byte_sel(shadow, '0, 2'd3);
          end
        end
        PAYLOAD: begin
          if (tx_ready) begin
            csum <= csum ^ tx_data;
            cnt  <= cnt_nxt;
            if (cnt == LAST_CNT) begin
              state   <= CHECK;
              tx_data <= csum ^ tx_data;
            end else begin
              tx_data <= rnn_byte_sel(shadow, cnt_nxt[CNT_W-1:2], ~cnt_nxt[1:0]);
            end
          end
        end
        CHECK: begin
          if (tx_ready) begin
            state       <= IDLE;
            tx_valid    <= 1'b0;
            res_ready   <= 1'b1;
            frames_sent <= frames_sent + 16'd1;
          end
        end
        default: begin
          state     <= IDLE;
          tx_valid  <= 1'b0;
          res_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rnn_result_tx.sv
// Scoreboard bench for rnn_result_tx: a reference framer pushes expected
// bytes, a negedge monitor pops and compares every accepted byte.
module tb_rnn_result_tx;
  import rnn_result_tx_pkg::*;

  localparam int FRAME_LEN = FRAME_PAYLOAD_BYTES + 2;

  logic                        clk = 1'b0;
  logic                        rst_n;
  logic                        res_valid;
  logic                        res_ready;
  logic [FLOAT_W-1:0]          vad;
  logic [NB_BANDS*FLOAT_W-1:0] gains;
  logic [7:0]                  tx_data;
  logic                        tx_valid;
  logic                        tx_ready;
  logic [15:0]                 frames_sent;

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0] exp_q[$];
  int         byte_idx  = 0;
  int         extra     = 0;
  int         idle_run  = 0;
  int         last_gap  = -1;
  logic [7:0] last_csum = 8'h00;
  logic [15:0] fs_at_hdr = 16'h0;

  rnn_result_tx dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .vad         (vad),
    .gains       (gains),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .frames_sent (frames_sent)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference framer: header, words MSB-first, XOR of payload.
  task automatic push_frame(input logic [FLOAT_W-1:0] v, input logic [NB_BANDS*FLOAT_W-1:0] g);
    logic [7:0]  cs;
    logic [31:0] w;
    cs = 8'h00;
    exp_q.push_back(RNN_HDR);
    for (int k = 0; k <= NB_BANDS; k++) begin
      w = (k == 0) ? v : g[(k-1)*FLOAT_W +: FLOAT_W];
      for (int b = 0; b < 4; b++) begin
        exp_q.push_back(w[31:24]);
        cs = cs ^ w[31:24];
        w  = w << 8;
      end
    end
    exp_q.push_back(cs);
  endtask

  // Monitor: a byte is accepted at the next posedge when valid && ready here.
  always @(negedge clk) begin
    if (rst_n) begin
      if (!tx_valid) idle_run++;
      if (tx_valid && tx_ready) begin
        if (byte_idx == 0) begin
          last_gap  = idle_run;
          fs_at_hdr = frames_sent;
          chk("res_ready_busy", {31'b0, res_ready}, 32'd0);
        end
        idle_run = 0;
        if (exp_q.size() == 0) extra++;
        else chk($sformatf("byte%0d", byte_idx), {24'b0, tx_data}, {24'b0, exp_q.pop_front()});
        if (byte_idx == FRAME_LEN - 1) begin
          last_csum = tx_data;
          byte_idx  = 0;
        end else byte_idx++;
      end
    end
  end

  task automatic start_frame(input logic [FLOAT_W-1:0] v, input logic [NB_BANDS*FLOAT_W-1:0] g);
    chk("res_ready_idle", {31'b0, res_ready}, 32'd1);
    vad = v; gains = g; res_valid = 1'b1;
    push_frame(v, g);
    @(posedge clk); #1;
    res_valid = 1'b0;
  endtask

  task automatic wait_idx(input int target, input string tag);
    for (int i = 0; i < 500 && byte_idx != target; i++) begin
      @(posedge clk); #1;
    end
    chk(tag, byte_idx, target);
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 3000 && (exp_q.size() != 0 || tx_valid); i++) begin
      @(posedge clk); #1;
    end
    chk(tag, exp_q.size(), 0);
  endtask

  logic [NB_BANDS*FLOAT_W-1:0] g_ord;
  logic [NB_BANDS*FLOAT_W-1:0] g_zero;

  initial begin
    g_zero = '0;
    for (int i = 0; i < NB_BANDS; i++) g_ord[i*FLOAT_W +: FLOAT_W] = 32'h01020300 + i;
    rst_n = 1'b0; res_valid = 1'b0; vad = '0; gains = '0; tx_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_tx_valid", {31'b0, tx_valid}, 32'd0);
    chk("rst_tx_data", {24'b0, tx_data}, 32'd0);
    chk("rst_res_ready", {31'b0, res_ready}, 32'd1);
    chk("rst_frames", {16'b0, frames_sent}, 32'd0);
    @(posedge clk); #1;

    // Reset at payload byte 40 aborts the frame.
    start_frame(32'h12345678, g_ord);
    wait_idx(41, "mid_reset_reach");
    rst_n = 1'b0;
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    byte_idx = 0;
    @(negedge clk);
    chk("mid_rst_tx_valid", {31'b0, tx_valid}, 32'd0);
    chk("mid_rst_res_ready", {31'b0, res_ready}, 32'd1);
    chk("mid_rst_frames", {16'b0, frames_sent}, 32'd0);
    @(posedge clk); #1;

    // Basic frame.
    start_frame(32'h3F800000, g_zero);
    wait_drain("basic_drain");
    chk("basic_csum", {24'b0, last_csum}, 32'hBF);
    chk("basic_frames", {16'b0, frames_sent}, 32'd1);

    // Backpressure on byte 2.
    start_frame(32'h3F800000, g_zero);
    wait_idx(2, "bp_reach");
    tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", {31'b0, tx_valid}, 32'd1);
      chk("bp_data", {24'b0, tx_data}, 32'h80);
    end
    @(posedge clk); #1;
    tx_ready = 1'b1;
    wait_drain("bp_drain");
    chk("bp_csum", {24'b0, last_csum}, 32'hBF);
    chk("bp_frames", {16'b0, frames_sent}, 32'd2);

    // Ordering frame, with an ignored result offered at payload byte 10.
    start_frame(32'hDEADBEEF, g_ord);
    wait_idx(11, "ign_reach");
    vad = 32'hCAFEF00D; gains = ~g_ord; res_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("ign_res_ready", {31'b0, res_ready}, 32'd0);
    end
    @(posedge clk); #1;
    res_valid = 1'b0;
    wait_drain("ord_drain");
    repeat (120) @(posedge clk);
    #1;
    chk("ign_no_second", extra, 0);
    chk("ign_idle", {31'b0, tx_valid}, 32'd0);
    chk("ord_frames", {16'b0, frames_sent}, 32'd3);

    // Counter wrap plus back-to-back frames with res_valid held.
    force dut.frames_sent = 16'hFFFF;
    @(posedge clk); #1;
    release dut.frames_sent;
    vad = 32'h40490FDB; gains = g_ord; res_valid = 1'b1;
    push_frame(32'h40490FDB, g_ord);
    push_frame(32'h40490FDB, g_ord);
    @(posedge clk); #1;
    wait_idx(1, "b2b_first_hdr");
    wait_idx(0, "b2b_first_end");
    wait_idx(1, "b2b_second_hdr");
    res_valid = 1'b0;
    chk("wrap_frames", {16'b0, fs_at_hdr}, 32'd0);
    chk("b2b_gap", last_gap, 1);
    wait_drain("b2b_drain");
    chk("b2b_frames", {16'b0, frames_sent}, 32'd1);
    repeat (120) @(posedge clk);
    #1;
    chk("final_extra", extra, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
